psram_apb_arbiter: RTL

PSRAM_APB_ARBITER -- requirements
Module: psram_apb_arbiter

---
 rtl/psram_apb_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/psram_apb_arbiter.sv
// psram_apb_arbiter
//   Two-requester APB arbiter in front of a single PSRAM APB controller.
//   Each requester (m0, m1) raises psel to ask for a transfer. The arbiter
//   picks one winner while idle, copies its request into the out_* register
//   set and runs a normal SETUP/ACCESS cycle toward the controller. The
//   response is routed back only to the winner. A simultaneous request is
//   resolved round-robin: the requester not served last wins.
//
// Ports
//   clk, resetn          : clock (rising edge), asynchronous active-low reset
//   mN_paddr .. mN_pstrb : APB request from requester N (N = 0, 1)
//   mN_pready/prdata/pslverr : APB response to requester N
//   out_paddr .. out_pstrb   : APB master side toward the PSRAM controller
//   out_pready/prdata/pslverr: response from the PSRAM controller
//   gnt                  : index of the current or most recent grant (debug)

module psram_apb_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic [2:0]        m0_pprot,
  input  logic              m0_pwrite,
  input  logic [31:0]       m0_pwdata,
  input  logic [3:0]        m0_pstrb,
  output logic              m0_pready,
  output logic [31:0]       m0_prdata,
  output logic              m0_pslverr,

  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic [2:0]        m1_pprot,
  input  logic              m1_pwrite,
  input  logic [31:0]       m1_pwdata,
  input  logic [3:0]        m1_pstrb,
  output logic              m1_pready,
  output logic [31:0]       m1_prdata,
  output logic              m1_pslverr,

  output logic [ADDR_W-1:0] out_paddr,
  output logic              out_psel,
  output logic              out_penable,
  output logic [2:0]        out_pprot,
  output logic              out_pwrite,
  output logic [31:0]       out_pwdata,
  output logic [3:0]        out_pstrb,
  input  logic              out_pready,
  input  logic [31:0]       out_prdata,
  input  logic              out_pslverr,

  output logic              gnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_next;

  logic grant;       // requester owning the current/most recent transfer
  logic last_grant;  // requester whose transfer completed most recently
  logic any_req;
  logic winner;

  // Requester penable carries no meaning for arbitration; only psel is a request.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and APB control outputs. psel/penable are decoded from the
  // state so an asynchronous reset drops them in the same cycle.
  always_comb begin
    state_next  = state;
    out_psel    = 1'b0;
    out_penable = 1'b0;
    any_req     = m0_psel | m1_psel;
    // On a tie the requester not served last wins; otherwise the lone requester.
    if (m0_psel && m1_psel) winner = ~last_grant;
    else                    winner = m1_psel;

    case (state)
      IDLE: begin
        if (any_req) state_next = SETUP;
      end
      SETUP: begin
        out_psel   = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        out_psel    = 1'b1;
        out_penable = 1'b1;
        if (out_pready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant bookkeeping and the request copy driven toward the controller.
  // The copy is taken only on the IDLE->SETUP step and then held, which keeps
  // the downstream transfer intact even if the requester drops psel.
  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      out_paddr  <= '0;
      out_pprot  <= '0;
      out_pwrite <= 1'b0;
      out_pwdata <= '0;
      out_pstrb  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant <= winner;
        if (winner) begin
          out_paddr  <= m1_paddr;
          out_pprot  <= m1_pprot;
          out_pwrite <= m1_pwrite;
          out_pwdata <= m1_pwdata;
          out_pstrb  <= m1_pstrb;
        end else begin
          out_paddr  <= m0_paddr;
          out_pprot  <= m0_pprot;
          out_pwrite <= m0_pwrite;
          out_pwdata <= m0_pwdata;
          out_pstrb  <= m0_pstrb;
        end
      end
      if (state == ACCESS && out_pready) last_grant <= grant;
    end
  end

  assign gnt = grant;

  // Responses reach only the granted requester, and only during ACCESS.
  assign m0_pready  = (state == ACCESS) && !grant && out_pready;
  assign m1_pready  = (state == ACCESS) &&  grant && out_pready;
  assign m0_prdata  = ((state == ACCESS) && !grant) ? out_prdata  : 32'h0;
  assign m1_prdata  = ((state == ACCESS) &&  grant) ? out_prdata  : 32'h0;
  assign m0_pslverr = ((state == ACCESS) && !grant) ? out_pslverr : 1'b0;
  assign m1_pslverr = ((state == ACCESS) &&  grant) ? out_pslverr : 1'b0;

endmodule
